reset_sequencer: RTL and testbench

- Generates the downstream active-low synchronous reset `o_rst_n` for the `o_q` ring-counter stage.
- That stage uses this reset as its `i_srst`, with low meaning "in reset".
- Guarantees every low pulse on `o_rst_n` lasts at least MIN_LOW clock cycles, which satisfies the downstream "reset low for ≥4 cycles" property by construction.
- Merges a level reset request and a single-cycle software pulse. Adds a post-release settle window before flagging ready, and counts completed reset sequences.

---
 rtl/reset_sequencer.sv | 128 ++++++++++++
 tb/tb_reset_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Downstream reset sequencer: stretches merged reset requests into a low pulse of at
// least MIN_LOW cycles, waits a settle window, then flags ready and counts completed sequences.
module reset_sequencer #(
  parameter int MIN_LOW       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_req,
  input  logic             i_sw_pulse,
  output logic             o_rst_n,
  output logic             o_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);

  localparam int LO_W = (MIN_LOW > 1) ? $clog2(MIN_LOW) : 1;
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(MIN_LOW - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam bit SKIP_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [LO_W-1:0]  lo_cnt, lo_cnt_nx;
  logic [ST_W-1:0]  st_cnt, st_cnt_nx;
  logic             rst_n_nx, ready_nx, busy_nx;
  logic [CNT_W-1:0] count_nx;
  logic             req;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign req = i_req | i_sw_pulse;

  always_comb begin
    state_nx  = state;
    lo_cnt_nx = lo_cnt;
    st_cnt_nx = st_cnt;
    rst_n_nx  = o_rst_n;
    ready_nx  = o_ready;
    count_nx  = o_count;
    case (state)
      S_ASSERT: begin
        // A new request restarts the low window, so the pulse always ends MIN_LOW edges after the last one.
        if (req) begin
          lo_cnt_nx = '0;
        end else if (lo_cnt == LO_LAST) begin
          rst_n_nx = 1'b1;
          if (SKIP_SETTLE) begin
            state_nx = S_RUN;
            ready_nx = 1'b1;
            count_nx = sat_inc(o_count);
          end else begin
            state_nx  = S_SETTLE;
            st_cnt_nx = '0;
          end
        end else begin
          lo_cnt_nx = lo_cnt + LO_W'(1);
        end
      end
      S_SETTLE: begin
        if (req) begin
          state_nx  = S_ASSERT;
          lo_cnt_nx = '0;
          rst_n_nx  = 1'b0;
        end else if (st_cnt == ST_LAST) begin
          state_nx = S_RUN;
          ready_nx = 1'b1;
          count_nx = sat_inc(o_count);
        end else begin
          st_cnt_nx = st_cnt + ST_W'(1);
        end
      end
      S_RUN: begin
        if (req) begin
          state_nx  = S_ASSERT;
          lo_cnt_nx = '0;
          rst_n_nx  = 1'b0;
          ready_nx  = 1'b0;
        end
      end
      default: begin
        state_nx  = S_ASSERT;
        lo_cnt_nx = '0;
        rst_n_nx  = 1'b0;
        ready_nx  = 1'b0;
      end
    endcase
    busy_nx = (state_nx != S_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state   <= S_ASSERT;
      lo_cnt  <= '0;
      st_cnt  <= '0;
      o_rst_n <= 1'b0;
      o_ready <= 1'b0;
      o_busy  <= 1'b1;
      o_count <= '0;
    end else begin
      state   <= state_nx;
      lo_cnt  <= lo_cnt_nx;
      st_cnt  <= st_cnt_nx;
      o_rst_n <= rst_n_nx;
      o_ready <= ready_nx;
      o_busy  <= busy_nx;
      o_count <= count_nx;
    end
  end

  // Output invariants the downstream stage relies on.
  a_low_pulse: assert property (@(posedge i_clk) disable iff (i_srst)
    $fell(o_rst_n) |-> !o_rst_n [*MIN_LOW]);
  a_ready_rst: assert property (@(posedge i_clk) disable iff (i_srst)
    o_ready |-> o_rst_n);
  a_busy_ready: assert property (@(posedge i_clk) disable iff (i_srst)
    o_busy == !o_ready);

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: per-edge expected rst_n/ready masks, count follows
// each completed sequence with saturation.
module tb_reset_sequencer;

  localparam int MIN_LOW       = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int CNT_W         = 8;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;

  logic             i_clk      = 1'b0;
  logic             i_srst     = 1'b1;
  logic             i_req      = 1'b0;
  logic             i_sw_pulse = 1'b0;
  logic             o_rst_n;
  logic             o_ready;
  logic             o_busy;
  logic [CNT_W-1:0] o_count;

  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer #(
    .MIN_LOW      (MIN_LOW),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk     (i_clk),
    .i_srst    (i_srst),
    .i_req     (i_req),
    .i_sw_pulse(i_sw_pulse),
    .o_rst_n   (o_rst_n),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_count   (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Bit j of each mask is the input applied before / output expected after relative edge j.
  task automatic seq(input string name, input int nedges,
                     input logic [31:0] pulse_m, input logic [31:0] req_m,
                     input logic [31:0] rstn_m, input logic [31:0] ready_m,
                     input int cnt0);
    bit seen_nready;
    int cexp;
    seen_nready = 1'b0;
    for (int j = 0; j < nedges; j++) begin
      i_sw_pulse = pulse_m[j];
      i_req      = req_m[j];
      tick();
      if (!ready_m[j]) seen_nready = 1'b1;
      cexp = (ready_m[j] && seen_nready) ? ((cnt0 + 1 > CNT_MAX) ? CNT_MAX : cnt0 + 1) : cnt0;
      chk($sformatf("%s rst_n@%0d", name, j), 32'(o_rst_n), 32'(rstn_m[j]));
      chk($sformatf("%s ready@%0d", name, j), 32'(o_ready), 32'(ready_m[j]));
      chk($sformatf("%s busy@%0d", name, j), 32'(o_busy), 32'(!ready_m[j]));
      chk($sformatf("%s count@%0d", name, j), 32'(o_count), 32'(cexp));
    end
    i_sw_pulse = 1'b0;
    i_req      = 1'b0;
  endtask

  initial begin
    // Power-on reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("por rst_n@%0d", i), 32'(o_rst_n), 32'd0);
      chk($sformatf("por ready@%0d", i), 32'(o_ready), 32'd0);
      chk($sformatf("por busy@%0d", i), 32'(o_busy), 32'd1);
      chk($sformatf("por count@%0d", i), 32'(o_count), 32'd0);
    end
    i_srst = 1'b0;
    seq("por_release", 8, 32'h0, 32'h0, 32'hF8, 32'hE0, 0);

    seq("sw_pulse",      8, 32'h1,  32'h0,   32'hF0,    32'hC0,    1);
    seq("req_level",    17, 32'h0,  32'h3FF, 32'h1E000, 32'h18000, 2);
    seq("retrigger",    10, 32'h5,  32'h0,   32'h3C0,   32'h300,   3);
    seq("req_settle",   13, 32'h1,  32'h20,  32'h1E10,  32'h1800,  4);
    seq("req_and_sw",    8, 32'h1,  32'h1,   32'hF0,    32'hC0,    5);
    seq("term_assert",  11, 32'h9,  32'h0,   32'h780,   32'h600,   6);
    seq("term_settle",  14, 32'h41, 32'h0,   32'h3C30,  32'h3000,  7);

    // 256 back-to-back sequences drive the counter into saturation.
    for (int i = 0; i < 256; i++) begin
      i_sw_pulse = 1'b1;
      tick();
      i_sw_pulse = 1'b0;
      repeat (6) tick();
      if (i == 100) chk("count_mid_sat", 32'(o_count), 32'd109);
    end
    chk("count_saturated", 32'(o_count), 32'(CNT_MAX));
    chk("ready_after_sat", 32'(o_ready), 32'd1);
    seq("sat_hold", 8, 32'h1, 32'h0, 32'hF0, 32'hC0, CNT_MAX);

    // Block reset landing in SETTLE, with a request present, overrides everything.
    i_sw_pulse = 1'b1;
    tick();
    i_sw_pulse = 1'b0;
    repeat (4) tick();
    chk("pre_srst rst_n", 32'(o_rst_n), 32'd1);
    chk("pre_srst ready", 32'(o_ready), 32'd0);
    i_srst = 1'b1;
    i_req  = 1'b1;
    tick();
    chk("mid_srst rst_n", 32'(o_rst_n), 32'd0);
    chk("mid_srst ready", 32'(o_ready), 32'd0);
    chk("mid_srst busy", 32'(o_busy), 32'd1);
    chk("mid_srst count", 32'(o_count), 32'd0);
    i_srst = 1'b0;
    i_req  = 1'b0;
    seq("srst_release", 8, 32'h0, 32'h0, 32'hF8, 32'hE0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
